// File: rtl/gshare_predictor.sv
// Branch-direction predictor: table of saturating counters indexed by
// PC XOR speculative global history (gshare) or by PC alone (bimodal).
// The table is cleared by a one-entry-per-cycle sweep after reset so that
// it never needs a parallel reset and can live in RAM.
module gshare_predictor #(
    parameter int PC_WIDTH    = 10,
    parameter int INDEX_WIDTH = 5,
    parameter int CTR_WIDTH   = 2,
    parameter int GHR_WIDTH   = 5,
    parameter int USE_GSHARE  = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ready,
    input  logic                   pred_req,
    input  logic [PC_WIDTH-1:0]    pred_pc,
    output logic                   pred_valid,
    output logic                   pred_taken,
    output logic [INDEX_WIDTH-1:0] pred_index,
    output logic [GHR_WIDTH-1:0]   pred_ghr,
    input  logic                   upd_valid,
    input  logic [INDEX_WIDTH-1:0] upd_index,
    input  logic                   upd_taken,
    input  logic                   upd_mispredict,
    input  logic [GHR_WIDTH-1:0]   upd_ghr,
    output logic [CNT_WIDTH-1:0]   mispredict_count
);

    localparam int DEPTH = 1 << INDEX_WIDTH;
    // Weakly-not-taken start value; collapses to 0 for 1-bit counters.
    localparam logic [CTR_WIDTH-1:0] CTR_WNT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [INDEX_WIDTH-1:0] sweep_ptr;
    logic [GHR_WIDTH-1:0]   ghr;
    logic [CTR_WIDTH-1:0]   ctr_table [DEPTH];

    logic [INDEX_WIDTH-1:0] ghr_ext;
    logic [INDEX_WIDTH-1:0] pred_idx;
    logic                   pred_bit;
    logic                   tbl_we;
    logic [INDEX_WIDTH-1:0] tbl_waddr;
    logic [CTR_WIDTH-1:0]   tbl_wdata;
    logic                   run;
    logic                   repair;
    logic                   pc_hi_unused;

    // Counter moves one step toward the outcome, pinned at 0 and all-ones.
    function automatic logic [CTR_WIDTH-1:0] ctr_step(input logic [CTR_WIDTH-1:0] c,
                                                      input logic up);
        if (up)
            return (c == {CTR_WIDTH{1'b1}}) ? c : c + 1'b1;
        else
            return (c == '0) ? c : c - 1'b1;
    endfunction

    // Statistics counter stops at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] cnt_sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == {CNT_WIDTH{1'b1}}) ? c : c + 1'b1;
    endfunction

    // Shift one outcome into a history value; shift form works for width 1 too.
    function automatic logic [GHR_WIDTH-1:0] ghr_shift(input logic [GHR_WIDTH-1:0] h,
                                                       input logic b);
        return (h << 1) | GHR_WIDTH'(b);
    endfunction

    assign run          = (state == S_RUN);
    assign ready        = run;
    assign repair       = upd_valid && upd_mispredict;
    assign pc_hi_unused = ^pred_pc;

    // Next-state logic: sweep ends after the last table entry is written.
    always_comb begin
        state_next = state;
        if (state == S_INIT && sweep_ptr == LAST_IDX)
            state_next = S_RUN;
    end

    // Predict-side index and table read, plus single write-port steering.
    always_comb begin
        ghr_ext = '0;
        ghr_ext[GHR_WIDTH-1:0] = ghr;
        pred_idx = (USE_GSHARE != 0) ? (pred_pc[INDEX_WIDTH-1:0] ^ ghr_ext)
                                     : pred_pc[INDEX_WIDTH-1:0];
        pred_bit = ctr_table[pred_idx][CTR_WIDTH-1];
        tbl_we    = 1'b0;
        tbl_waddr = upd_index;
        tbl_wdata = ctr_step(ctr_table[upd_index], upd_taken);
        if (!run) begin
            tbl_we    = 1'b1;
            tbl_waddr = sweep_ptr;
            tbl_wdata = CTR_WNT;
        end else if (upd_valid) begin
            tbl_we = 1'b1;
        end
    end

    // State register and sweep pointer; reset restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            sweep_ptr <= '0;
        end else begin
            state <= state_next;
            if (!run)
                sweep_ptr <= sweep_ptr + 1'b1;
        end
    end

    // Global history: repair on mispredict wins over speculative shift.
    always_ff @(posedge clk) begin
        if (rst)
            ghr <= '0;
        else if (run) begin
            if (repair)
                ghr <= ghr_shift(upd_ghr, upd_taken);
            else if (pred_req)
                ghr <= ghr_shift(ghr, pred_bit);
        end
    end

    // Mispredict statistics, saturating.
    always_ff @(posedge clk) begin
        if (rst)
            mispredict_count <= '0;
        else if (run && repair)
            mispredict_count <= cnt_sat_inc(mispredict_count);
    end

    // Registered prediction outputs; only the valid flag is reset.
    always_ff @(posedge clk) begin
        if (rst)
            pred_valid <= 1'b0;
        else
            pred_valid <= run && pred_req;
        if (run && pred_req) begin
            pred_taken <= pred_bit;
            pred_index <= pred_idx;
            pred_ghr   <= ghr;
        end
    end

    // Counter table write port; nonblocking write gives read-before-write.
    always_ff @(posedge clk) begin
        if (tbl_we)
            ctr_table[tbl_waddr] <= tbl_wdata;
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor with default parameters
// (32-entry table, 2-bit counters, 5-bit history).
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        pred_req;
    logic [9:0]  pred_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [4:0]  pred_index;
    logic [4:0]  pred_ghr;
    logic        upd_valid;
    logic [4:0]  upd_index;
    logic        upd_taken;
    logic        upd_mispredict;
    logic [4:0]  upd_ghr;
    logic [15:0] mispredict_count;

    int n_checks = 0;
    int n_pass   = 0;

    gshare_predictor #(
        .PC_WIDTH(10), .INDEX_WIDTH(5), .CTR_WIDTH(2),
        .GHR_WIDTH(5), .USE_GSHARE(1), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_index(pred_index), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_index(upd_index),
        .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
        .upd_ghr(upd_ghr), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pred(input logic req, input int pc);
        pred_req = req;
        pred_pc  = 10'(pc);
    endtask

    task automatic set_upd(input logic v, input int idx, input logic t,
                           input logic mis, input int g);
        upd_valid      = v;
        upd_index      = 5'(idx);
        upd_taken      = t;
        upd_mispredict = mis;
        upd_ghr        = 5'(g);
    endtask

    task automatic chk_pred(input string tag, input logic t, input int idx, input int g);
        check({tag, ".valid"}, 32'(pred_valid), 32'd1);
        check({tag, ".taken"}, 32'(pred_taken), 32'(t));
        check({tag, ".index"}, 32'(pred_index), 32'(idx));
        check({tag, ".ghr"},   32'(pred_ghr),   32'(g));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        set_pred(1'b0, 0);
        set_upd(1'b0, 0, 1'b0, 1'b0, 0);
        step();
        rst = 1'b0;
        check("rst.ready", 32'(ready), 32'd0);
        check("rst.pvalid", 32'(pred_valid), 32'd0);
        check("rst.count", 32'(mispredict_count), 32'd0);
        for (int i = 1; i <= 32; i++) begin
            step();
            if (i == 31) check("init.ready31", 32'(ready), 32'd0);
            if (i == 32) check("init.ready32", 32'(ready), 32'd1);
        end

        // Every entry starts weakly not-taken; history stays 0.
        for (int i = 0; i < 32; i++) begin
            set_pred(1'b1, i);
            step();
            chk_pred($sformatf("dflt%0d", i), 1'b0, i, 0);
        end
        set_pred(1'b0, 0);
        step();
        check("dflt.idle", 32'(pred_valid), 32'd0);

        // Saturation high: idx3 1->2->3->3->3, then predict taken.
        for (int k = 0; k < 4; k++) begin
            set_upd(1'b1, 3, 1'b1, 1'b0, 0);
            step();
        end
        set_upd(1'b0, 0, 1'b0, 1'b0, 0);
        set_pred(1'b1, 3);
        step();
        chk_pred("sat_hi", 1'b1, 3, 0);
        set_pred(1'b0, 0);

        // Saturation low: idx7 1->0->0->0; ghr=1, pc=6 maps to 7.
        for (int k = 0; k < 3; k++) begin
            set_upd(1'b1, 7, 1'b0, 1'b0, 0);
            step();
        end
        set_upd(1'b0, 0, 1'b0, 1'b0, 0);
        set_pred(1'b1, 6);
        step();
        chk_pred("sat_lo", 1'b0, 7, 1);
        set_pred(1'b0, 0);

        // Repair ghr to 0 (idx0 decremented), make idx5 taken.
        set_upd(1'b1, 0, 1'b0, 1'b1, 0);
        step();
        check("repair0.count", 32'(mispredict_count), 32'd1);
        set_upd(1'b1, 5, 1'b1, 1'b0, 0);
        step();
        set_upd(1'b0, 0, 1'b0, 1'b0, 0);

        // Back-to-back predicts of pc=5: ghr 0 -> 1 -> 2.
        set_pred(1'b1, 5);
        step();
        chk_pred("spec1", 1'b1, 5, 0);
        step();
        chk_pred("spec2", 1'b0, 4, 1);
        step();
        chk_pred("spec3", 1'b0, 7, 2);

        // Predict (ghr=4) with same-cycle mispredict repair -> ghr 01101.
        set_pred(1'b1, 0);
        set_upd(1'b1, 9, 1'b1, 1'b1, 5'b00110);
        step();
        chk_pred("both", 1'b0, 4, 4);
        check("both.count", 32'(mispredict_count), 32'd2);
        set_upd(1'b0, 0, 1'b0, 1'b0, 0);
        step();
        chk_pred("after_repair", 1'b0, 13, 13);

        // Read-before-write: ghr=26, pc=16 -> idx10 updated taken same cycle.
        set_pred(1'b1, 16);
        set_upd(1'b1, 10, 1'b1, 1'b0, 0);
        step();
        chk_pred("rbw", 1'b0, 10, 26);
        set_upd(1'b0, 0, 1'b0, 1'b0, 0);
        set_pred(1'b1, 30);
        step();
        chk_pred("rbw_after", 1'b1, 10, 20);
        check("rbw.count", 32'(mispredict_count), 32'd2);
        set_pred(1'b0, 0);
        step();
        check("run.idle", 32'(pred_valid), 32'd0);

        // Reset in RUN with a pending request.
        set_pred(1'b1, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_pred(1'b0, 0);
        check("rstrun.pvalid", 32'(pred_valid), 32'd0);
        check("rstrun.ready", 32'(ready), 32'd0);
        check("rstrun.count", 32'(mispredict_count), 32'd0);

        // Reset again at sweep pointer 10.
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstinit.ready", 32'(ready), 32'd0);
        check("rstinit.count", 32'(mispredict_count), 32'd0);

        // Requests and updates during the sweep are ignored.
        set_pred(1'b1, 3);
        set_upd(1'b1, 3, 1'b1, 1'b1, 31);
        for (int i = 1; i <= 32; i++) begin
            step();
            if (i == 16) begin
                check("sweep.pvalid", 32'(pred_valid), 32'd0);
                check("sweep.count", 32'(mispredict_count), 32'd0);
            end
            if (i == 31) check("sweep.ready31", 32'(ready), 32'd0);
            if (i == 32) check("sweep.ready32", 32'(ready), 32'd1);
        end
        set_upd(1'b0, 0, 1'b0, 1'b0, 0);
        check("sweep.count_end", 32'(mispredict_count), 32'd0);
        step();
        chk_pred("post_sweep", 1'b0, 3, 0);
        set_pred(1'b0, 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
